// File: rtl/xt_lsu_pkg.sv
// Shared types and constants for the xt load/store unit.
// funct3 codes, bus width codes, error and state encodings, request checker.
package xt_lsu_pkg;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  localparam logic [1:0] WW_BYTE = 2'd0;
  localparam logic [1:0] WW_HALF = 2'd1;
  localparam logic [1:0] WW_WORD = 2'd2;

  typedef enum logic [1:0] {
    LSU_OK       = 2'd0,
    LSU_MISALIGN = 2'd1,
    LSU_ILLEGAL  = 2'd2,
    LSU_TIMEOUT  = 2'd3
  } lsu_err_t;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_t;

  // Illegal encodings win over misalignment.
  function automatic lsu_err_t lsu_check(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ill;
    logic mis;
    ill = we ? (f3 > 3'd2)
             : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    mis = (f3[1:0] == WW_HALF && a[0])
       || (f3[1:0] == WW_WORD && a != 2'b00);
    if (ill)
      return LSU_ILLEGAL;
    else if (mis)
      return LSU_MISALIGN;
    else
      return LSU_OK;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data extension for RV32I LB/LH/LW/LBU/LHU.
// In: funct3, raw right-justified RAM data. Out: extended word.
module lsu_load_extend
  import xt_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    unique case (1'b1)
      funct3 == LSU_LB:  ext = {{24{raw[7]}}, raw[7:0]};
      funct3 == LSU_LH:  ext = {{16{raw[15]}}, raw[15:0]};
      funct3 == LSU_LBU: ext = {24'd0, raw[7:0]};
      funct3 == LSU_LHU: ext = {16'd0, raw[15:0]};
      default:           ext = raw;
    endcase
  end

endmodule

// File: rtl/xt_load_store_unit.sv
// Core-side load/store unit mastering the data-RAM high-speed bus.
// Ports: req_* (core request), resp_* (completion), hb_* (RAM bus).
// Optional bus watchdog enabled by defining XT_LSU_TIMEOUT_EN.
module xt_load_store_unit
  import xt_lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              hb_clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic [ADDR_W-1:0] hb_raddr,
  output logic [ADDR_W-1:0] hb_waddr,
  output logic [31:0]       hb_wdata,
  output logic [1:0]        hb_write_width,
  output logic              hb_ren,
  output logic              hb_wen,
  input  logic [31:0]       hb_rdata,
  input  logic              hb_wait_finish
);

  lsu_state_t        state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        width_q;
  logic [31:0]       rdata_q;
  lsu_err_t          err_q;
  lsu_err_t          chk;
  logic [31:0]       ext;
  logic              accept;
  logic              in_acc;
  logic              to_hit;

  assign chk    = lsu_check(req_we, req_funct3, req_addr[1:0]);
  assign accept = req_valid && state == LSU_IDLE;
  assign in_acc = state == LSU_ACCESS;

  lsu_load_extend u_ext (
    .funct3 (f3_q),
    .raw    (hb_rdata),
    .ext    (ext)
  );

`ifdef XT_LSU_TIMEOUT_EN
  localparam int TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W   = (TO_RAW > 8) ? TO_RAW : 8;

  logic [TO_W-1:0] to_cnt;

  // Fires on the last allowed wait cycle, so the strobe
  // is high for exactly TIMEOUT_CYCLES cycles.
  assign to_hit = in_acc && !hb_wait_finish
               && to_cnt == TO_W'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge hb_clk) begin
    if (rst)
      to_cnt <= '0;
    else if (accept)
      to_cnt <= '0;
    else if (in_acc && !hb_wait_finish)
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge hb_clk) begin
    if (rst) begin
      state   <= LSU_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      rdata_q <= '0;
      err_q   <= LSU_OK;
    end else begin
      unique case (state)
        LSU_IDLE: begin
          if (accept) begin
            we_q <= req_we;
            f3_q <= req_funct3;
            if (chk == LSU_OK) begin
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              width_q <= req_funct3[1:0];
              state   <= LSU_ACCESS;
            end else begin
              rdata_q <= '0;
              err_q   <= chk;
              state   <= LSU_RESP;
            end
          end
        end
        LSU_ACCESS: begin
          if (hb_wait_finish) begin
            rdata_q <= we_q ? 32'd0 : ext;
            err_q   <= LSU_OK;
            state   <= LSU_RESP;
          end else if (to_hit) begin
            rdata_q <= '0;
            err_q   <= LSU_TIMEOUT;
            state   <= LSU_RESP;
          end
        end
        LSU_RESP: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

  assign req_ready      = state == LSU_IDLE;
  assign resp_valid     = state == LSU_RESP;
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign hb_raddr       = addr_q;
  assign hb_waddr       = addr_q;
  assign hb_wdata       = wdata_q;
  assign hb_write_width = width_q;
  assign hb_ren         = in_acc && !we_q;
  assign hb_wen         = in_acc && we_q;

endmodule

// File: tb/tb_xt_load_store_unit.sv
// Directed bench for xt_load_store_unit.
// One task per scenario, inline checks, single summary line.
module tb_xt_load_store_unit;
  import xt_lsu_pkg::*;

  logic        hb_clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] hb_raddr;
  logic [31:0] hb_waddr;
  logic [31:0] hb_wdata;
  logic [1:0]  hb_write_width;
  logic        hb_ren;
  logic        hb_wen;
  logic [31:0] hb_rdata = '0;
  logic        hb_wait_finish = 1'b0;

  logic [2:0]  ref_f3 = '0;
  logic [31:0] ref_raw = '0;
  logic [31:0] ref_ext;

  int total = 0;
  int bad = 0;

  always #5 hb_clk = ~hb_clk;

  xt_load_store_unit #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .hb_clk         (hb_clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .hb_raddr       (hb_raddr),
    .hb_waddr       (hb_waddr),
    .hb_wdata       (hb_wdata),
    .hb_write_width (hb_write_width),
    .hb_ren         (hb_ren),
    .hb_wen         (hb_wen),
    .hb_rdata       (hb_rdata),
    .hb_wait_finish (hb_wait_finish)
  );

  lsu_load_extend u_ref (
    .funct3 (ref_f3),
    .raw    (ref_raw),
    .ext    (ref_ext)
  );

  task automatic step();
    @(posedge hb_clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b exp=1", req_ready);
    end
    total++;
    if ({resp_valid, hb_ren, hb_wen} !== 3'b000) begin
      bad++; $display("FAIL rst_strobes got=%b exp=000",
                      {resp_valid, hb_ren, hb_wen});
    end
    total++;
    if ({resp_rdata, resp_err} !== 34'd0) begin
      bad++; $display("FAIL rst_resp got=%h/%0d exp=0/0",
                      resp_rdata, resp_err);
    end
    total++;
    if ({hb_raddr, hb_wdata, hb_write_width} !== 66'd0) begin
      bad++; $display("FAIL rst_bus got=%h/%h/%0d exp=0",
                      hb_raddr, hb_wdata, hb_write_width);
    end
  endtask

  task automatic test_lw_wait();
    drive_req(1'b0, LSU_LW, 32'h10, 32'h0);
    step();
    req_valid = 1'b0;
    total++;
    if ({hb_ren, hb_wen, resp_valid, req_ready} !== 4'b1000) begin
      bad++; $display("FAIL lw_t1 got=%b exp=1000",
                      {hb_ren, hb_wen, resp_valid, req_ready});
    end
    total++;
    if (hb_raddr !== 32'h10 || hb_write_width !== 2'd2) begin
      bad++; $display("FAIL lw_addr got=%h/%0d exp=10/2",
                      hb_raddr, hb_write_width);
    end
    step();
    total++;
    if (hb_ren !== 1'b1 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL lw_t2 got=%b%b exp=10", hb_ren, resp_valid);
    end
    hb_wait_finish = 1'b1;
    hb_rdata = 32'h8765_4321;
    step();
    hb_wait_finish = 1'b0;
    hb_rdata = 32'h0;
    total++;
    if (hb_ren !== 1'b0 || resp_valid !== 1'b1 || req_ready !== 1'b0) begin
      bad++; $display("FAIL lw_t3 got=%b%b%b exp=010",
                      hb_ren, resp_valid, req_ready);
    end
    total++;
    if (resp_rdata !== 32'h8765_4321 || resp_err !== 2'd0) begin
      bad++; $display("FAIL lw_data got=%h/%0d exp=87654321/0",
                      resp_rdata, resp_err);
    end
    step();
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL lw_t4 got=%b%b exp=01", resp_valid, req_ready);
    end
  endtask

  logic [2:0]  t_f3  [6] = '{LSU_LB, LSU_LBU, LSU_LH,
                             LSU_LHU, LSU_LB, LSU_LH};
  logic [31:0] t_adr [6] = '{32'h13, 32'h13, 32'h12,
                             32'h12, 32'h10, 32'h12};
  logic [31:0] t_raw [6] = '{32'h0000_00F0, 32'h0000_00F0, 32'h0000_8001,
                             32'h0000_8001, 32'h0000_007F, 32'h0000_7FFF};
  logic [31:0] t_exp [6] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8001,
                             32'h0000_8001, 32'h0000_007F, 32'h0000_7FFF};

  task automatic test_load_ext();
    for (int i = 0; i < 6; i++) begin
      drive_req(1'b0, t_f3[i], t_adr[i], 32'h0);
      step();
      req_valid = 1'b0;
      total++;
      if (hb_ren !== 1'b1 || hb_raddr !== t_adr[i]) begin
        bad++; $display("FAIL ext%0d_bus got=%b/%h exp=1/%h",
                        i, hb_ren, hb_raddr, t_adr[i]);
      end
      hb_wait_finish = 1'b1;
      hb_rdata = t_raw[i];
      step();
      hb_wait_finish = 1'b0;
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== t_exp[i]
          || resp_err !== 2'd0) begin
        bad++; $display("FAIL ext%0d_data got=%b/%h/%0d exp=1/%h/0",
                        i, resp_valid, resp_rdata, resp_err, t_exp[i]);
      end
      step();
    end
  endtask

  task automatic test_load_ref();
    logic [2:0] fs [4] = '{LSU_LB, LSU_LH, LSU_LBU, LSU_LHU};
    for (int i = 0; i < 4; i++) begin
      ref_f3  = fs[i];
      ref_raw = $urandom() | 32'h0000_8080;
      if (fs[i][1:0] == 2'd0)
        ref_raw = ref_raw & 32'h0000_00FF;
      else
        ref_raw = ref_raw & 32'h0000_FFFF;
      drive_req(1'b0, fs[i], 32'h40, 32'h0);
      step();
      req_valid = 1'b0;
      hb_wait_finish = 1'b1;
      hb_rdata = ref_raw;
      step();
      hb_wait_finish = 1'b0;
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== ref_ext) begin
        bad++; $display("FAIL ref%0d got=%b/%h exp=1/%h",
                        i, resp_valid, resp_rdata, ref_ext);
      end
      step();
    end
  endtask

  task automatic test_store();
    hb_rdata = 32'hDEAD_BEEF;
    drive_req(1'b1, LSU_SH, 32'h22, 32'h1234_ABCD);
    step();
    req_valid = 1'b0;
    total++;
    if (hb_wen !== 1'b1 || hb_ren !== 1'b0) begin
      bad++; $display("FAIL sh_t1 got=%b%b exp=10", hb_wen, hb_ren);
    end
    total++;
    if (hb_waddr !== 32'h22 || hb_write_width !== 2'd1
        || hb_wdata !== 32'h1234_ABCD) begin
      bad++; $display("FAIL sh_bus got=%h/%0d/%h exp=22/1/1234abcd",
                      hb_waddr, hb_write_width, hb_wdata);
    end
    hb_wait_finish = 1'b1;
    step();
    hb_wait_finish = 1'b0;
    total++;
    if (hb_wen !== 1'b0 || resp_valid !== 1'b1) begin
      bad++; $display("FAIL sh_t2 got=%b%b exp=01", hb_wen, resp_valid);
    end
    total++;
    if (resp_rdata !== 32'd0 || resp_err !== 2'd0) begin
      bad++; $display("FAIL sh_resp got=%h/%0d exp=0/0",
                      resp_rdata, resp_err);
    end
    total++;
    if (hb_waddr !== 32'h22 || hb_wdata !== 32'h1234_ABCD) begin
      bad++; $display("FAIL sh_hold got=%h/%h exp=22/1234abcd",
                      hb_waddr, hb_wdata);
    end
    hb_rdata = 32'h0;
    step();
  endtask

  logic        e_we  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [2:0]  e_f3  [5] = '{LSU_LW, 3'b110, 3'b011, LSU_LH, LSU_SW};
  logic [31:0] e_adr [5] = '{32'h06, 32'h10, 32'h01, 32'h11, 32'h02};
  logic [1:0]  e_exp [5] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd1};

  task automatic test_errors();
    for (int i = 0; i < 5; i++) begin
      drive_req(e_we[i], e_f3[i], e_adr[i], 32'hFFFF_FFFF);
      step();
      req_valid = 1'b0;
      total++;
      if (resp_valid !== 1'b1 || resp_err !== e_exp[i]
          || resp_rdata !== 32'd0) begin
        bad++; $display("FAIL err%0d got=%b/%0d/%h exp=1/%0d/0",
                        i, resp_valid, resp_err, resp_rdata, e_exp[i]);
      end
      total++;
      if (hb_ren !== 1'b0 || hb_wen !== 1'b0 || hb_waddr !== 32'h22) begin
        bad++; $display("FAIL err%0d_bus got=%b%b/%h exp=00/22",
                        i, hb_ren, hb_wen, hb_waddr);
      end
      step();
      total++;
      if (hb_ren !== 1'b0 || hb_wen !== 1'b0 || req_ready !== 1'b1) begin
        bad++; $display("FAIL err%0d_after got=%b%b%b exp=001",
                        i, hb_ren, hb_wen, req_ready);
      end
    end
  endtask

  task automatic test_busy_ignored();
    drive_req(1'b0, LSU_LW, 32'h80, 32'h0);
    step();
    drive_req(1'b1, LSU_SW, 32'h84, 32'h5555_5555);
    step();
    total++;
    if (hb_ren !== 1'b1 || hb_wen !== 1'b0 || hb_raddr !== 32'h80
        || req_ready !== 1'b0) begin
      bad++; $display("FAIL busy got=%b%b%b/%h exp=100/80",
                      hb_ren, hb_wen, req_ready, hb_raddr);
    end
    hb_wait_finish = 1'b1;
    hb_rdata = 32'h0BAD_F00D;
    step();
    hb_wait_finish = 1'b0;
    req_valid = 1'b0;
    total++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BAD_F00D
        || req_ready !== 1'b0) begin
      bad++; $display("FAIL busy_resp got=%b%b/%h exp=10/0badf00d",
                      resp_valid, req_ready, resp_rdata);
    end
    step();
    total++;
    if (resp_valid !== 1'b0 || hb_wen !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL busy_idle got=%b%b%b exp=001",
                      resp_valid, hb_wen, req_ready);
    end
  endtask

  task automatic test_rst_mid();
    drive_req(1'b0, LSU_LW, 32'h30, 32'h0);
    step();
    req_valid = 1'b0;
    total++;
    if (hb_ren !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre got=%b exp=1", hb_ren);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (hb_ren !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid got=%b%b%b exp=001",
                      hb_ren, resp_valid, req_ready);
    end
    step();
    total++;
    if (resp_valid !== 1'b0 || hb_ren !== 1'b0) begin
      bad++; $display("FAIL rstmid_after got=%b%b exp=00",
                      resp_valid, hb_ren);
    end
  endtask

  task automatic test_timeout();
    int ren_cnt;
    bit seen;
    ren_cnt = 0;
    seen = 1'b0;
    drive_req(1'b0, LSU_LW, 32'h50, 32'h0);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      if (hb_ren) ren_cnt++;
      step();
    end
`ifdef XT_LSU_TIMEOUT_EN
    total++;
    if (seen !== 1'b1 || ren_cnt != 4) begin
      bad++; $display("FAIL timeout got=%b/%0d exp=1/4", seen, ren_cnt);
    end
    total++;
    if (resp_err !== 2'd3 || resp_rdata !== 32'd0) begin
      bad++; $display("FAIL timeout_resp got=%0d/%h exp=3/0",
                      resp_err, resp_rdata);
    end
    step();
`else
    total++;
    if (seen !== 1'b0 || ren_cnt != 12) begin
      bad++; $display("FAIL nowdog got=%b/%0d exp=0/12", seen, ren_cnt);
    end
    hb_wait_finish = 1'b1;
    hb_rdata = 32'h1111_2222;
    step();
    hb_wait_finish = 1'b0;
    total++;
    if (resp_valid !== 1'b1 || resp_err !== 2'd0
        || resp_rdata !== 32'h1111_2222) begin
      bad++; $display("FAIL nowdog_resp got=%b/%0d/%h exp=1/0/11112222",
                      resp_valid, resp_err, resp_rdata);
    end
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_load_ext();
    test_load_ref();
    test_store();
    test_errors();
    test_busy_ignored();
    test_rst_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xt_load_store_unit.md
Name: xt_load_store_unit

Overview:
- Core-side load/store unit that masters the high-speed bus into the Harvard system data RAM.
- Accepts one RV32I load or store per request.
- Checks alignment, drives the address, write width, ren/wen and write data.
- Waits on the RAM wait/finish handshake, then sign- or zero-extends returned data before handing it back to the core.
- Sits directly upstream of the data-RAM byte-addressing interface.

Parameters:
- ADDR_W, 32, bus address width.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- hb_clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit idle, request accepted when req_valid&req_ready.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rs2, unshifted).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data (0 for stores and errors).
- resp_err  out  2  0=ok, 1=misaligned, 2=illegal funct3, 3=bus timeout.
- hb_raddr  out  ADDR_W  bus read address.
- hb_waddr  out  ADDR_W  bus write address.
- hb_wdata  out  32  bus write data.
- hb_write_width  out  2  0=byte, 1=half, 2=word.
- hb_ren  out  1  read strobe.
- hb_wen  out  1  write strobe.
- hb_rdata  in  32  RAM read data (byte/half zero-extended, right-justified).
- hb_wait_finish  in  1  RAM access complete.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - State returns to IDLE.
  - All outputs become 0, except req_ready=1.
  - Any in-flight ren/wen drops at that edge.
  - The aborted access produces no resp_valid.
- States: IDLE, ACCESS, RESP. req_ready=1 only in IDLE.
- IDLE: on accept, register we, funct3, addr and wdata.
  - Legal and aligned → ACCESS.
  - Otherwise → RESP with the error code and no bus strobe.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0; byte is always aligned.
- Illegal funct3: loads 011/110/111; stores >010. Illegal takes precedence over misaligned.
- ACCESS:
  - Drive hb_raddr/hb_waddr from the registered address.
  - hb_write_width = funct3[1:0].
  - hb_wdata = registered wdata, unmodified; the RAM replicates lanes.
  - Hold hb_ren (load) or hb_wen (store) continuously until hb_wait_finish=1 is sampled.
  - In that cycle, capture hb_rdata, drop the strobe and → RESP.
- Store: wen is high for exactly 1 cycle when finish is immediate.
- Load extension:
  - LB: bit 7 into [31:8]. LBU: zeros.
  - LH: bit 15 into [31:16]. LHU: zeros.
  - LW: passthrough.
- RESP: resp_valid=1 for one cycle with resp_rdata/resp_err, then → IDLE.
  - A new request is accepted no earlier than the cycle after resp_valid.
- Latency, accept at cycle T0 with zero-wait write:
  - Store: wen at T1, resp_valid at T2.
  - Load against the 1-wait RAM: ren at T1–T2, finish at T2, resp_valid at T3.
  - Error: resp_valid at T1.
- req_valid while busy is ignored (no queueing). The core must hold the request until req_ready.
- hb_raddr/hb_waddr and hb_write_width are held stable throughout ACCESS.
- Outside ACCESS, address and data outputs hold their last value and strobes are 0.

Optional Feature:
- Macro XT_LSU_TIMEOUT_EN.
- Defined: an 8+-bit counter clears on entering ACCESS and increments each ACCESS cycle without hb_wait_finish.
  - Reaching TIMEOUT_CYCLES drops the strobe and goes to RESP with resp_err=3 and resp_rdata=0.
- Undefined: no counter; ACCESS waits indefinitely and resp_err never equals 3.

Decomposition:
- Shared package XT_LSU_PKG:
  - funct3 constants (LSU_LB…LSU_SW).
  - lsu_err_t enum (OK, MISALIGN, ILLEGAL, TIMEOUT).
  - lsu_state_t enum.
  - width encoding constants matching the bus write_width.
- One combinational sub-module, lsu_load_extend: inputs funct3 and raw data, output the extended word. It is reused by the bench as a reference model.

Test Plan:
- LW addr 0x10, RAM word 0x8765_4321 (finish one cycle after ren) → ren high T1–T2, resp_valid at T3, rdata 0x8765_4321, err 0.
- LB addr 0x13 with hb_rdata 0x0000_00F0 → rdata 0xFFFF_FFF0; LBU same → 0x0000_00F0; LH addr 0x12 data 0x0000_8001 → 0xFFFF_8001.
- SH addr 0x22 wdata 0x1234_ABCD → wen 1 cycle at T1, waddr 0x22, width 1, wdata 0x1234_ABCD, resp_valid T2, rdata 0.
- LW addr 0x06 → no ren/wen ever, resp_valid at T1 with err 1; funct3 110 load → err 2.
- rst asserted in the ACCESS cycle of a load → ren 0 next cycle, no resp_valid, req_ready 1.
- With XT_LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, hb_wait_finish tied 0 → ren for 4 cycles, then resp_valid with err 3.
